// File: rtl/oka_pkg.sv
// Shared constants and FSM state type for the 26-bit overlap-free Karatsuba
// multiplier sequencer.
package oka_pkg;
   localparam int N  = 26;
   localparam int H  = N / 2;
   localparam int PW = 2 * H - 1;
   localparam int RW = 2 * N - 1;

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
endpackage

// File: rtl/gf2_mult_13bit.sv
// Combinational 13x13 carry-less (GF(2)) schoolbook multiplier.
// The result is the XOR of shifted partial-product rows.
module gf2_mult_13bit
   import oka_pkg::*;
(
   input  logic [H-1:0]  x,
   input  logic [H-1:0]  y,
   output logic [PW-1:0] z
);
   logic [PW-1:0] row [H];

   genvar gi;
   for (gi = 0; gi < H; gi++) begin : g_row
      assign row[gi] = y[gi] ? (PW'(x) << gi) : '0;
   end

   always_comb begin
      z = '0;
      for (int i = 0; i < H; i++) begin
         z = z ^ row[i];
      end
   end
endmodule

// File: rtl/oka_26bit_mult_sequencer.sv
// 26-bit GF(2) multiplier: four even/odd half-products through one shared
// 13x13 multiplier, recombined with the overlap-free Karatsuba mapping.
module oka_26bit_mult_sequencer
   import oka_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  a,
   input  logic [N-1:0]  b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [RW-1:0] p,
   output logic          busy
);
   state_t        state_reg, state_next;
   logic [1:0]    cnt_reg;
   logic [N-1:0]  a_reg, b_reg;
   logic [PW-1:0] p1_reg, p2_reg, p3_reg;
   logic [RW-1:0] p_reg;
   logic [H-1:0]  a_e, a_o, b_e, b_o;
   logic [H-1:0]  mul_x, mul_y;
   logic [PW-1:0] mul_z;
   logic [RW-1:0] comb_p;
   logic          accept;

   genvar gi;
   for (gi = 0; gi < H; gi++) begin : g_split
      assign a_e[gi] = a_reg[2*gi];
      assign a_o[gi] = a_reg[2*gi+1];
      assign b_e[gi] = b_reg[2*gi];
      assign b_o[gi] = b_reg[2*gi+1];
   end

   always_comb begin
      mul_x = a_e;
      mul_y = b_e;
      unique case (cnt_reg)
         2'd0: begin mul_x = a_e; mul_y = b_e; end
         2'd1: begin mul_x = a_e; mul_y = b_o; end
         2'd2: begin mul_x = a_o; mul_y = b_e; end
         default: begin mul_x = a_o; mul_y = b_o; end
      endcase
   end

   gf2_mult_13bit u_mult (
      .x (mul_x),
      .y (mul_y),
      .z (mul_z)
   );

   // P4 is never stored: on the last MUL cycle it is taken live from the multiplier.
   assign comb_p[0]     = p1_reg[0];
   assign comb_p[4*H-2] = mul_z[PW-1];
   for (gi = 1; gi <= 2*H-2; gi++) begin : g_even
      assign comb_p[2*gi] = p1_reg[gi] ^ mul_z[gi-1];
   end
   for (gi = 0; gi <= 2*H-2; gi++) begin : g_odd
      assign comb_p[2*gi+1] = p2_reg[gi] ^ p3_reg[gi];
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      unique case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = MUL;
         end
         MUL: begin
            busy = 1'b1;
            if (cnt_reg == 2'd3) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               in_ready   = 1'b1;
               state_next = in_valid ? MUL : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign accept = in_valid & in_ready;
   assign p      = p_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         p1_reg    <= '0;
         p2_reg    <= '0;
         p3_reg    <= '0;
         p_reg     <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            a_reg   <= a;
            b_reg   <= b;
            cnt_reg <= '0;
         end else if (state_reg == MUL) begin
            cnt_reg <= cnt_reg + 2'd1;
            unique case (cnt_reg)
               2'd0: p1_reg <= mul_z;
               2'd1: p2_reg <= mul_z;
               2'd2: p3_reg <= mul_z;
               default: p_reg <= comb_p;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_oka_26bit_mult_sequencer.sv
// Scoreboard bench for oka_26bit_mult_sequencer: expected products are queued
// on accept and compared when a result is handed downstream.
module tb_oka_26bit_mult_sequencer;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [25:0] a, b;
   logic        out_valid;
   logic        out_ready;
   logic [50:0] p;
   logic        busy;

   logic [50:0] sb [$];
   logic [50:0] exp_p;
   int          n_vec  = 0;
   int          n_miss = 0;
   int          cyc    = 0;

   oka_26bit_mult_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_miss++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   function automatic logic [50:0] clmul_ref(input logic [25:0] x, input logic [25:0] y);
      logic [50:0] r;
      r = '0;
      for (int i = 0; i < 26; i++)
         if (y[i]) r = r ^ (51'(x) << i);
      return r;
   endfunction

   // Handshakes are sampled on the falling edge; inputs only move just after rising edges.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check_val("sb_empty", 64'd1, 64'd0);
            end else begin
               exp_p = sb.pop_front();
               check_val("p_sb", 64'(p), 64'(exp_p));
            end
         end
         if (in_valid && in_ready) sb.push_back(clmul_ref(a, b));
      end
   end

   task automatic do_op(input logic [25:0] aa, input logic [25:0] bb,
                        output int lat, output int done_cyc);
      a = aa;
      b = bb;
      in_valid = 1'b1;
      for (int w = 0; w < 20 && !in_ready; w++) begin
         @(posedge clk); #1;
      end
      check_val("in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      done_cyc = cyc;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [25:0] da [4];
      logic [25:0] db [4];
      logic [50:0] dp [4];
      logic [25:0] x1, y1, x2, y2;
      int lat, dc, prev_dc;

      da[0] = 26'h1;       db[0] = 26'h1;       dp[0] = 51'h1;
      da[1] = 26'h3;       db[1] = 26'h3;       dp[1] = 51'h5;
      da[2] = 26'h2000000; db[2] = 26'h2000000; dp[2] = 51'h4_0000_0000_0000;
      da[3] = 26'h3FFFFFF; db[3] = 26'h1;       dp[3] = 51'h3FFFFFF;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_out_valid", 64'(out_valid), 64'd0);
      check_val("rst_p", 64'(p), 64'd0);
      check_val("rst_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      #1;
      check_val("rst_in_ready", 64'(in_ready), 64'd1);

      for (int k = 0; k < 4; k++) begin
         do_op(da[k], db[k], lat, dc);
         check_val("lat_dir", 64'(lat), 64'd4);
         check_val("p_dir", 64'(p), 64'(dp[k]));
      end

      for (int k = 0; k < 1000; k++) begin
         do_op(26'($urandom()), 26'($urandom()), lat, dc);
         check_val("lat_rnd", 64'(lat), 64'd4);
      end

      prev_dc = 0;
      for (int k = 0; k < 8; k++) begin
         do_op(26'($urandom()), 26'($urandom()), lat, dc);
         if (k > 0) check_val("ii", 64'(dc - prev_dc), 64'd5);
         prev_dc = dc;
      end

      // Backpressure: hold result, ignore new operands, then swap on one edge.
      @(posedge clk); #1;
      out_ready = 1'b0;
      x1 = 26'h2A5_5A3C; y1 = 26'h13C_0FF1;
      x2 = 26'h0F0_F0F1; y2 = 26'h3FF_0003;
      do_op(x1, y1, lat, dc);
      check_val("lat_bp", 64'(lat), 64'd4);
      for (int i = 0; i < 10; i++) begin
         check_val("bp_p", 64'(p), 64'(clmul_ref(x1, y1)));
         check_val("bp_in_ready", 64'(in_ready), 64'd0);
         if (i == 2) begin
            a = x2; b = y2; in_valid = 1'b1;
         end
         @(posedge clk); #1;
      end
      check_val("bp_hold_valid", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      #1;
      check_val("bp_in_ready_fwd", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      check_val("bp_busy", 64'(busy), 64'd1);
      a = 26'h155_5555; b = 26'h2AA_AAAA;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 2) in_valid = 1'b0;
      end
      check_val("lat_bp2", 64'(lat), 64'd4);
      check_val("p_bp2", 64'(p), 64'(clmul_ref(x2, y2)));

      // Reset in the middle of MUL discards the partial result.
      @(posedge clk); #1;
      a = 26'h5; b = 26'h7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check_val("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check_val("mid_rst_p", 64'(p), 64'd0);
      check_val("mid_rst_busy", 64'(busy), 64'd0);
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check_val("mid_rst_in_ready", 64'(in_ready), 64'd1);
      do_op(26'h2, 26'h2, lat, dc);
      check_val("lat_post_rst", 64'(lat), 64'd4);
      check_val("p_post_rst", 64'(p), 64'h4);

      @(posedge clk); #1;
      @(posedge clk); #1;
      check_val("sb_drained", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
